// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates two register-file write sources onto a single write port.
//   The primary (in-order writeback) normally wins; the secondary
//   (long-latency unit) is served when the primary is idle, when both
//   target the same register (secondary value is stale and is dropped),
//   or after STARVE_LIMIT consecutive refusals, when one forced cycle
//   gives it priority and stalls the primary.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   p_valid/p_rd/p_data primary write request
//   p_stall             combinational: primary must hold its request
//   s_valid/s_rd/s_data secondary write request
//   s_ready             combinational: secondary request consumed
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_data,
  output logic        p_stall,
  input  logic        s_valid,
  input  logic [4:0]  s_rd,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic {PRI = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic        kill;
  logic        p_acc, s_acc, s_refused;
  logic        win_valid;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  // Same destination in both requests: the primary value is newer, so the
  // secondary can be consumed and thrown away.
  assign kill = p_valid & s_valid & (p_rd == s_rd);

  assign p_acc     = p_valid & ~p_stall & ~rst;
  assign s_acc     = s_valid & s_ready;
  assign s_refused = s_valid & ~s_ready;

  assign wait_cnt_inc = (wait_cnt_reg == 4'd15) ? 4'd15 : wait_cnt_reg + 4'd1;

  always_comb begin
    p_stall       = 1'b0;
    s_ready       = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = 4'd0;
    win_valid     = 1'b0;
    win_rd        = p_rd;
    win_data      = p_data;

    // Handshake outputs are held inactive during reset so nothing is consumed.
    if (!rst) begin
      case (state_reg)
        PRI: begin
          s_ready = s_valid & (~p_valid | kill);
        end
        FORCE: begin
          s_ready = s_valid;
          p_stall = p_valid & s_valid;
        end
        default: ;
      endcase
    end

    // Winner: secondary only when forced, otherwise the accepted primary,
    // otherwise a lone accepted secondary. A killed secondary never wins.
    if (state_reg == FORCE && s_acc) begin
      win_valid = 1'b1;
      win_rd    = s_rd;
      win_data  = s_data;
    end else if (p_acc) begin
      win_valid = 1'b1;
    end else if (s_acc) begin
      win_valid = 1'b1;
      win_rd    = s_rd;
      win_data  = s_data;
    end

    if (s_refused)
      wait_cnt_next = wait_cnt_inc;

    case (state_reg)
      PRI:     if (s_refused && wait_cnt_inc == LIMIT) state_next = FORCE;
      FORCE:   if (!s_refused) state_next = PRI;
      default: state_next = PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= PRI;
      wait_cnt_reg <= 4'd0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'd0;
      rf_wdata     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      // Writes to x0 are accepted but never reach the register file.
      rf_we        <= win_valid & (win_rd != 5'd0);
      if (win_valid) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by random
// traffic, checked against a refusal-streak reference model with a
// scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_rd = '0;
  logic [31:0] p_data = '0;
  logic        p_stall;
  logic        s_valid = 1'b0;
  logic [4:0]  s_rd = '0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
    .s_valid(s_valid), .s_rd(s_rd), .s_data(s_data), .s_ready(s_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  streak = 0;   // consecutive cycles the secondary has been refused

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus reference-model evaluation.
  task automatic cyc(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                     input bit sv, input logic [4:0] srd, input logic [31:0] sd,
                     output bit ost, output bit osr, output bit pa, output bit sa);
    bit  forced, est, esr, wv;
    wr_t w;
    @(negedge clk);
    rst = r; p_valid = pv; p_rd = prd; p_data = pd;
    s_valid = sv; s_rd = srd; s_data = sd;
    #1;
    est = 0; esr = 0; pa = 0; sa = 0; wv = 0;
    w.rd = '0; w.data = '0;
    if (!r) begin
      // Secondary gets priority once it has been refused LIMIT times in a row.
      forced = (streak >= LIMIT);
      if (forced) begin
        esr = sv;
        est = pv & sv;
      end else begin
        esr = sv & (!pv || prd == srd);
      end
      pa = pv & !est;
      sa = sv & esr;
      if (forced && sv) begin wv = 1; w.rd = srd; w.data = sd; end
      else if (pa)      begin wv = 1; w.rd = prd; w.data = pd; end
      else if (sa)      begin wv = 1; w.rd = srd; w.data = sd; end
      if (wv && w.rd != 5'd0) exp_q.push_back(w);
      streak = (sv && !esr) ? streak + 1 : 0;
    end else begin
      streak = 0;
    end
    chk("p_stall", 32'(p_stall), 32'(est));
    chk("s_ready", 32'(s_ready), 32'(esr));
    ost = p_stall; osr = s_ready;
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #1;
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got rd=%0d data=%08h required none", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
          chk("rf_wdata", rf_wdata, e.data);
          $display("[TB] write rd=%0d data=%08h", rf_waddr, rf_wdata);
        end
      end
    end
  end

  initial begin
    bit st, sr, pa, sa;
    bit hp, hs;
    logic [4:0]  hp_rd, hs_rd;
    logic [31:0] hp_d, hs_d;

    // Reset with requests present: nothing may be consumed or written.
    cyc(1, 1, 5'd4, 32'h55, 1, 5'd6, 32'h66, st, sr, pa, sa);
    cyc(1, 1, 5'd4, 32'h55, 1, 5'd6, 32'h66, st, sr, pa, sa);
    @(posedge clk); #2;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);

    // Primary only.
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, st, sr, pa, sa);
    chk("pri_only_stall", 32'(st), 32'd0);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, sr, pa, sa);

    // Starvation: four refusals, then one forced secondary, then the primary.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 5'd3, 32'h100 + i, 1, 5'd7, 32'h11, st, sr, pa, sa);
      chk("starve_sready", 32'(sr), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("starve_pstall", 32'(st), 32'd1);
    cyc(0, 1, 5'd3, 32'h104, 0, 5'd0, 32'd0, st, sr, pa, sa);
    chk("after_force_pstall", 32'(st), 32'd0);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, sr, pa, sa);

    // Kill: same destination, only the primary value is written.
    cyc(0, 1, 5'd9, 32'hA, 1, 5'd9, 32'hB, st, sr, pa, sa);
    chk("kill_sready", 32'(sr), 32'd1);
    chk("kill_pstall", 32'(st), 32'd0);

    // x0 destination is accepted but not written.
    cyc(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, st, sr, pa, sa);
    chk("x0_pstall", 32'(st), 32'd0);

    // Secondary only.
    cyc(0, 0, 5'd0, 32'd0, 1, 5'd31, 32'h1234, st, sr, pa, sa);
    chk("sec_only_sready", 32'(sr), 32'd1);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, sr, pa, sa);

    // Mid-operation reset after three refusals restarts the starvation count.
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 5'd3, 32'h200 + i, 1, 5'd7, 32'h22, st, sr, pa, sa);
    cyc(1, 1, 5'd3, 32'h203, 1, 5'd7, 32'h22, st, sr, pa, sa);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 5'd3, 32'h300 + i, 1, 5'd7, 32'h33, st, sr, pa, sa);
      chk("rst_restart_sready", 32'(sr), (i == 4) ? 32'd1 : 32'd0);
    end
    cyc(0, 1, 5'd3, 32'h304, 0, 5'd0, 32'd0, st, sr, pa, sa);

    // Random traffic; requests are held until the model says they were accepted.
    hp = 0; hs = 0; hp_rd = '0; hs_rd = '0; hp_d = '0; hs_d = '0;
    for (int i = 0; i < 2000; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (!hp && $urandom_range(0, 9) < 6) begin
        hp = 1; hp_rd = 5'($urandom_range(0, 7)); hp_d = $urandom;
      end
      if (!hs && $urandom_range(0, 9) < 5) begin
        hs = 1; hs_rd = 5'($urandom_range(0, 7)); hs_d = $urandom;
      end
      cyc(r, hp, hp_rd, hp_d, hs, hs_rd, hs_d, st, sr, pa, sa);
      if (r) begin
        hp = 0; hs = 0;
      end else begin
        if (pa) hp = 0;
        if (sa) hs = 0;
      end
    end

    for (int i = 0; i < 4; i++)
      cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, st, sr, pa, sa);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
